// File: rtl/convt2d_tap_sequencer.sv
// convt2d_tap_sequencer
// Address/control sequencer for a transposed 2-D convolution datapath.
// Walks every (input channel, input row, input column, kernel row, kernel
// column) candidate and issues one scatter-accumulate beat for each tap that
// lands inside the output plane. Taps that fall outside the plane are skipped
// internally in a single cycle and never appear on the beat interface.
//
// Optional feature macro: CONVT2D_PERF_CNT_EN
//   defined   -> perf_cycles counts RUN cycles (saturating), cleared on start
//   undefined -> perf_cycles is tied to zero and no counter is built
module convt2d_tap_sequencer #(
  parameter int C_IN    = 4,
  parameter int H_IN    = 2,
  parameter int W_IN    = 3,
  parameter int K       = 3,
  parameter int STRIDE  = 2,
  parameter int PAD     = 1,
  parameter int OUT_PAD = 1,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       perf_cycles
);

  // Output plane size after removing padding and adding output padding.
  localparam int H_OUT = (H_IN - 1) * STRIDE - 2 * PAD + K + OUT_PAD;
  localparam int W_OUT = (W_IN - 1) * STRIDE - 2 * PAD + K + OUT_PAD;

  // Counter widths; a one-entry loop still needs a one-bit register.
  localparam int IC_W = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int IH_W = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam int IW_W = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int K_W  = (K    > 1) ? $clog2(K)    : 1;

  localparam logic [IC_W-1:0] IC_LAST = IC_W'(C_IN - 1);
  localparam logic [IH_W-1:0] IH_LAST = IH_W'(H_IN - 1);
  localparam logic [IW_W-1:0] IW_LAST = IW_W'(W_IN - 1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;

  logic [IC_W-1:0] ic;
  logic [IH_W-1:0] ih;
  logic [IW_W-1:0] iw;
  logic [K_W-1:0]  kh;
  logic [K_W-1:0]  kw;

  logic signed [31:0] oh;
  logic signed [31:0] ow;
  logic               in_range;
  logic               advance;
  logic               last_cand;
  logic               launch;

  // Target output coordinate of the current candidate and its range test.
  always_comb begin
    oh       = $signed(32'(ih)) * STRIDE - PAD + $signed(32'(kh));
    ow       = $signed(32'(iw)) * STRIDE - PAD + $signed(32'(kw));
    in_range = (oh >= 0) && (oh < H_OUT) && (ow >= 0) && (ow < W_OUT);
  end

  // A candidate retires when skipped (out of range) or when its beat is taken.
  always_comb begin
    launch    = (state == S_IDLE) && start && !abort;
    advance   = (state == S_RUN) && (!in_range || op_ready);
    last_cand = (ic == IC_LAST) && (ih == IH_LAST) && (iw == IW_LAST) &&
                (kh == K_LAST) && (kw == K_LAST);
  end

  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign op_valid = (state == S_RUN) && in_range;

  // Addresses at full 32-bit precision, truncated to the output width.
  assign in_addr  = ADDR_W'(32'(ic) * 32'(H_IN * W_IN) + 32'(ih) * 32'(W_IN) + 32'(iw));
  assign w_addr   = ADDR_W'(32'(ic) * 32'(K * K) + 32'(kh) * 32'(K) + 32'(kw));
  assign out_addr = ADDR_W'(oh * W_OUT + ow);

  // Control FSM and nested loop counters (kw fastest, ic slowest).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ic    <= '0;
      ih    <= '0;
      iw    <= '0;
      kh    <= '0;
      kw    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (launch) begin
            state <= S_RUN;
            ic    <= '0;
            ih    <= '0;
            iw    <= '0;
            kh    <= '0;
            kw    <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            ic    <= '0;
            ih    <= '0;
            iw    <= '0;
            kh    <= '0;
            kw    <= '0;
          end else if (advance) begin
            if (last_cand) begin
              state <= S_DONE;
              ic    <= '0;
              ih    <= '0;
              iw    <= '0;
              kh    <= '0;
              kw    <= '0;
            end else if (kw != K_LAST) begin
              kw <= kw + 1'b1;
            end else begin
              kw <= '0;
              if (kh != K_LAST) begin
                kh <= kh + 1'b1;
              end else begin
                kh <= '0;
                if (iw != IW_LAST) begin
                  iw <= iw + 1'b1;
                end else begin
                  iw <= '0;
                  if (ih != IH_LAST) begin
                    ih <= ih + 1'b1;
                  end else begin
                    ih <= '0;
                    ic <= ic + 1'b1;
                  end
                end
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ic    <= '0;
          ih    <= '0;
          iw    <= '0;
          kh    <= '0;
          kw    <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CONVT2D_PERF_CNT_EN
  logic [31:0] perf_q;

  // RUN-cycle counter: cleared on layer start, saturates, holds outside RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (launch) begin
      perf_q <= '0;
    end else if ((state == S_RUN) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_convt2d_tap_sequencer.sv
// tb_convt2d_tap_sequencer
// Directed bench with scoreboard queues: expected beats are generated by a
// loop model when a layer is started and popped as the sequencer issues them.
module tb_convt2d_tap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, op_ready;
  logic        busy, done, op_valid;
  logic [15:0] in_addr, w_addr, out_addr;
  logic [31:0] perf_cycles;

  logic        start2, abort2, op_ready2;
  logic        busy2, done2, op_valid2;
  logic [15:0] in_addr2, w_addr2, out_addr2;
  logic [31:0] perf_cycles2;

  int compared   = 0;
  int mismatched = 0;

  logic [47:0] q1[$];
  logic [47:0] q2[$];

  // dut monitor state
  int          run_cnt, beats, done_cnt, first_cyc;
  logic [47:0] first_addr, last_addr, held;
  logic        prev_stall, prev_busy;
  logic [31:0] perf_at_done;

  // dut2 monitor state
  int          run_cnt2, beats2, done_cnt2;
  int          max_out2, max_w2;

`ifdef CONVT2D_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  convt2d_tap_sequencer #(
    .C_IN(1), .H_IN(2), .W_IN(3), .K(3), .STRIDE(2), .PAD(1), .OUT_PAD(1), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
    .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr),
    .perf_cycles(perf_cycles)
  );

  convt2d_tap_sequencer #(
    .C_IN(4), .H_IN(2), .W_IN(2), .K(3), .STRIDE(1), .PAD(0), .OUT_PAD(0), .ADDR_W(16)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .op_valid(op_valid2), .op_ready(op_ready2),
    .in_addr(in_addr2), .w_addr(w_addr2), .out_addr(out_addr2),
    .perf_cycles(perf_cycles2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Loop model of the candidate walk; pushes in-range beats to a queue.
  task automatic fill(input int sel, input int cin, input int hin, input int win,
                      input int k, input int s, input int p, input int op);
    int hout;
    int wout;
    int oh;
    int ow;
    logic [47:0] e;
    hout = (hin - 1) * s - 2 * p + k + op;
    wout = (win - 1) * s - 2 * p + k + op;
    for (int c = 0; c < cin; c++)
      for (int y = 0; y < hin; y++)
        for (int x = 0; x < win; x++)
          for (int a = 0; a < k; a++)
            for (int b = 0; b < k; b++) begin
              oh = y * s - p + a;
              ow = x * s - p + b;
              if (oh >= 0 && oh < hout && ow >= 0 && ow < wout) begin
                e = {16'(c * hin * win + y * win + x), 16'(c * k * k + a * k + b),
                     16'(oh * wout + ow)};
                if (sel == 1) q1.push_back(e);
                else          q2.push_back(e);
              end
            end
  endtask

  task automatic clear_mon();
    run_cnt = 0; beats = 0; done_cnt = 0; first_cyc = -1;
    first_addr = '0; last_addr = '0; perf_at_done = '0;
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    step(1);
  endtask

  // Scoreboard and protocol monitor for the default-configuration instance.
  always @(negedge clk) begin
    logic [47:0] cur;
    logic [47:0] exp;
    cur = {in_addr, w_addr, out_addr};
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (busy) run_cnt++;
      if (done) begin
        done_cnt++;
        perf_at_done = perf_cycles;
        chk("done_follows_run", 64'(prev_busy), 64'd1);
      end
      if (prev_stall) chk("stall_hold", {15'd0, op_valid, cur}, {15'd0, 1'b1, held});
      if (op_valid && op_ready) begin
        beats++;
        if (beats == 1) begin
          first_cyc  = run_cnt;
          first_addr = cur;
        end
        last_addr = cur;
        if (q1.size() == 0) chk("sb_underflow", 64'(cur), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          exp = q1.pop_front();
          chk("beat", 64'(cur), 64'(exp));
        end
      end
      prev_stall = op_valid && !op_ready;
      held       = cur;
      prev_busy  = busy;
    end
  end

  // Scoreboard for the all-valid configuration instance.
  always @(negedge clk) begin
    logic [47:0] exp;
    if (rst_n) begin
      if (busy2) run_cnt2++;
      if (done2) done_cnt2++;
      if (op_valid2 && op_ready2) begin
        beats2++;
        if (int'(out_addr2) > max_out2) max_out2 = int'(out_addr2);
        if (int'(w_addr2) > max_w2) max_w2 = int'(w_addr2);
        if (q2.size() == 0) chk("sb2_underflow", 64'({in_addr2, w_addr2, out_addr2}), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          exp = q2.pop_front();
          chk("beat2", 64'({in_addr2, w_addr2, out_addr2}), 64'(exp));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_ready = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; op_ready2 = 1'b1;
    run_cnt2 = 0; beats2 = 0; done_cnt2 = 0; max_out2 = -1; max_w2 = -1;
    clear_mon();
    step(3);
    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_op_valid", 64'(op_valid), 64'd0);
    chk("rst_perf", 64'(perf_cycles), 64'd0);
    rst_n = 1'b1;
    step(2);

    // Full layer, op_ready high
    clear_mon();
    fill(1, 1, 2, 3, 3, 2, 1, 1);
    chk("model_beats", 64'(q1.size()), 64'd40);
    start = 1'b1; step(1); start = 1'b0;
    wait_done(200);
    chk("run_cycles", 64'(run_cnt), 64'd54);
    chk("beats", 64'(beats), 64'd40);
    chk("sb_drained", 64'(q1.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("first_beat_cycle", 64'(first_cyc), 64'd5);
    chk("first_beat_addr", 64'(first_addr), {16'd0, 16'd0, 16'd4, 16'd0});
    chk("last_beat_addr", 64'(last_addr), {16'd0, 16'd5, 16'd8, 16'd23});
    chk("perf_at_done", 64'(perf_at_done), PERF_ON ? 64'd54 : 64'd0);
    chk("idle_after_done_busy", 64'(busy), 64'd0);
    chk("done_one_cycle", 64'(done), 64'd0);

    // Three-cycle stall on the first beat
    clear_mon();
    fill(1, 1, 2, 3, 3, 2, 1, 1);
    op_ready = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(7);
    op_ready = 1'b1;
    wait_done(200);
    chk("stall_run_cycles", 64'(run_cnt), 64'd57);
    chk("stall_beats", 64'(beats), 64'd40);
    chk("stall_sb_drained", 64'(q1.size()), 64'd0);
    chk("stall_first_addr", 64'(first_addr), {16'd0, 16'd0, 16'd4, 16'd0});
    chk("stall_perf", 64'(perf_at_done), PERF_ON ? 64'd57 : 64'd0);

    // Abort on the 10th RUN cycle
    clear_mon();
    fill(1, 1, 2, 3, 3, 2, 1, 1);
    start = 1'b1; step(1); start = 1'b0;
    step(9);
    abort = 1'b1; step(1); abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_op_valid", 64'(op_valid), 64'd0);
    step(5);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; step(1); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", 64'(busy), 64'd0);
    step(1);
    q1.delete();
    // Replay after abort
    clear_mon();
    fill(1, 1, 2, 3, 3, 2, 1, 1);
    start = 1'b1; step(1); start = 1'b0;
    wait_done(200);
    chk("replay_first_addr", 64'(first_addr), {16'd0, 16'd0, 16'd4, 16'd0});
    chk("replay_beats", 64'(beats), 64'd40);
    chk("replay_sb_drained", 64'(q1.size()), 64'd0);

    // Second start mid-RUN is ignored
    clear_mon();
    fill(1, 1, 2, 3, 3, 2, 1, 1);
    start = 1'b1; step(1); start = 1'b0;
    step(20);
    start = 1'b1; step(1); start = 1'b0;
    wait_done(200);
    chk("restart_beats", 64'(beats), 64'd40);
    chk("restart_run_cycles", 64'(run_cnt), 64'd54);
    chk("restart_done_count", 64'(done_cnt), 64'd1);
    step(3);
    chk("restart_no_second_run", 64'(busy), 64'd0);

    // Reset mid-RUN
    clear_mon();
    fill(1, 1, 2, 3, 3, 2, 1, 1);
    start = 1'b1; step(1); start = 1'b0;
    step(9);
    rst_n = 1'b0; step(1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_op_valid", 64'(op_valid), 64'd0);
    chk("midrst_perf", 64'(perf_cycles), 64'd0);
    rst_n = 1'b1;
    step(3);
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    q1.delete();

    // All-valid configuration on the second instance
    fill(2, 4, 2, 2, 3, 1, 0, 0);
    start2 = 1'b1; step(1); start2 = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(negedge clk);
        if (done2) seen = 1'b1;
      end
      if (!seen) chk("done2_timeout", 64'd0, 64'd1);
    end
    step(1);
    chk("cfg2_beats", 64'(beats2), 64'd144);
    chk("cfg2_run_cycles", 64'(run_cnt2), 64'd144);
    chk("cfg2_max_out", 64'(max_out2), 64'd15);
    chk("cfg2_max_w", 64'(max_w2), 64'd35);
    chk("cfg2_sb_drained", 64'(q2.size()), 64'd0);
    chk("cfg2_done_count", 64'(done_cnt2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
